// File: rtl/sysmem_arbiter.sv
// sysmem_arbiter: shares four 1024x8 byte-lane BRAMs between the picorv32
// native memory port and a byte-wide host/loader port. Every access runs
// through IDLE -> ACCESS -> CAPTURE -> DONE. Round-robin arbitration is used
// when both requesters are active.
// Optional feature: define SYSMEM_WRITE_PROTECT_EN to add cpu_wr_fault. With
// the feature enabled, CPU writes to words below PROT_WORDS are blocked.
module sysmem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int PROT_WORDS = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_valid,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_wstrb,
  output logic              cpu_ready,
  output logic [31:0]       cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W+1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_ack,
  output logic [7:0]        host_rdata,
`ifdef SYSMEM_WRITE_PROTECT_EN
  output logic              cpu_wr_fault,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ce,
  output logic [3:0]        mem_we,
  output logic [31:0]       mem_di,
  input  logic [31:0]       mem_do
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

  localparam logic [ADDR_W:0] LP_PROT = (ADDR_W+1)'(PROT_WORDS);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_grant_cpu;
  logic               w_grant_host;
  logic               w_prot_hit;
  logic               w_unused;
  logic [7:0]         w_lane_byte;

  logic               r_last_host;   // 1 = host was granted most recently
  logic               r_sel_host;    // owner of the access in flight
  logic               r_is_read;     // only reads update the rdata registers
  logic [1:0]         r_lane;        // host byte lane for the read mux
  logic               r_prot;        // CPU write blocked by write protection
  logic [ADDR_W-1:0]  r_mem_addr;
  logic               r_mem_ce;
  logic [3:0]         r_mem_we;
  logic [31:0]        r_mem_di;
  logic               r_cpu_ready;
  logic [31:0]        r_cpu_rdata;
  logic               r_host_ack;
  logic [7:0]         r_host_rdata;
  logic               r_wr_fault;

  // CPU write aimed at the protected low region
  assign w_prot_hit  = (cpu_wstrb != 4'b0000) &&
                       ({1'b0, cpu_addr[ADDR_W+1:2]} < LP_PROT);
  assign w_lane_byte = mem_do[8*r_lane +: 8];
  // Upper CPU address bits alias by design; byte offset is unused for word access
  assign w_unused    = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0], w_prot_hit, r_prot, r_wr_fault};

  assign mem_addr   = r_mem_addr;
  assign mem_ce     = r_mem_ce;
  assign mem_we     = r_mem_we;
  assign mem_di     = r_mem_di;
  assign cpu_ready  = r_cpu_ready;
  assign cpu_rdata  = r_cpu_rdata;
  assign host_ack   = r_host_ack;
  assign host_rdata = r_host_rdata;
`ifdef SYSMEM_WRITE_PROTECT_EN
  assign cpu_wr_fault = r_wr_fault;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and round-robin grant decision
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_cpu  = 1'b0;
    w_grant_host = 1'b0;
    case (r_state)
      IDLE: begin
        if (cpu_valid && (!host_req || r_last_host)) begin
          w_grant_cpu = 1'b1;
          w_state_nxt = ACCESS;
        end else if (host_req) begin
          w_grant_host = 1'b1;
          w_state_nxt  = ACCESS;
        end
      end
      ACCESS:  w_state_nxt = CAPTURE;
      CAPTURE: w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Registered lane pins, read capture and completion pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_host  <= 1'b1;
      r_sel_host   <= 1'b0;
      r_is_read    <= 1'b0;
      r_lane       <= 2'd0;
      r_prot       <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_ce     <= 1'b0;
      r_mem_we     <= 4'b0000;
      r_mem_di     <= 32'h0;
      r_cpu_ready  <= 1'b0;
      r_cpu_rdata  <= 32'h0;
      r_host_ack   <= 1'b0;
      r_host_rdata <= 8'h00;
      r_wr_fault   <= 1'b0;
    end else begin
      r_cpu_ready <= 1'b0;
      r_host_ack  <= 1'b0;
      r_wr_fault  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_cpu) begin
            r_last_host <= 1'b0;
            r_sel_host  <= 1'b0;
            r_is_read   <= (cpu_wstrb == 4'b0000);
            r_mem_addr  <= cpu_addr[ADDR_W+1:2];
            r_mem_di    <= cpu_wdata;
            r_mem_ce    <= 1'b1;
`ifdef SYSMEM_WRITE_PROTECT_EN
            r_prot      <= w_prot_hit;
            r_mem_we    <= w_prot_hit ? 4'b0000 : cpu_wstrb;
`else
            r_prot      <= 1'b0;
            r_mem_we    <= cpu_wstrb;
`endif
          end else if (w_grant_host) begin
            r_last_host <= 1'b1;
            r_sel_host  <= 1'b1;
            r_is_read   <= !host_we;
            r_lane      <= host_addr[1:0];
            r_prot      <= 1'b0;
            r_mem_addr  <= host_addr[ADDR_W+1:2];
            r_mem_di    <= {4{host_wdata}};
            r_mem_we    <= host_we ? (4'b0001 << host_addr[1:0]) : 4'b0000;
            r_mem_ce    <= 1'b1;
          end
        end
        ACCESS: begin
          r_mem_ce <= 1'b0;
          r_mem_we <= 4'b0000;
        end
        CAPTURE: begin
          if (r_sel_host) begin
            r_host_ack <= 1'b1;
            if (r_is_read) r_host_rdata <= w_lane_byte;
          end else begin
            r_cpu_ready <= 1'b1;
            r_wr_fault  <= r_prot;
            if (r_is_read) r_cpu_rdata <= mem_do;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sysmem_arbiter.sv
// Directed testbench for sysmem_arbiter with a behavioural four-lane BRAM.
module tb_sysmem_arbiter;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_valid;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [3:0]        cpu_wstrb;
  logic              cpu_ready;
  logic [31:0]       cpu_rdata;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W+1:0] host_addr;
  logic [7:0]        host_wdata;
  logic              host_ack;
  logic [7:0]        host_rdata;
  logic              fault_w;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ce;
  logic [3:0]        mem_we;
  logic [31:0]       mem_di;
  logic [31:0]       mem_do;

  int errors = 0;
  int checks = 0;

  bit   [31:0] mem [0:1023];
  logic [31:0] nw;

  always #5 clk = ~clk;

  sysmem_arbiter #(.ADDR_W(ADDR_W), .PROT_WORDS(128)) dut (
    .clk(clk), .rst(rst),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
`ifdef SYSMEM_WRITE_PROTECT_EN
    .cpu_wr_fault(fault_w),
`endif
    .mem_addr(mem_addr), .mem_ce(mem_ce), .mem_we(mem_we),
    .mem_di(mem_di), .mem_do(mem_do)
  );

`ifndef SYSMEM_WRITE_PROTECT_EN
  assign fault_w = 1'b0;
`endif

  // Behavioural byte-lane BRAMs, read-first, 1-cycle read latency
  always @(posedge clk) begin
    if (mem_ce) begin
      mem_do <= mem[mem_addr];
      nw = mem[mem_addr];
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) nw[8*i +: 8] = mem_di[8*i +: 8];
      mem[mem_addr] <= nw;
    end
  end

  task automatic cpu_op(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, output logic [31:0] rdata,
                        output int lat, output logic [3:0] we_seen,
                        output logic [ADDR_W-1:0] addr_seen, output logic fault);
    cpu_valid = 1'b1; cpu_addr = addr; cpu_wdata = wdata; cpu_wstrb = wstrb;
    lat = 0; rdata = 32'h0; we_seen = 4'h0; addr_seen = '0; fault = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin we_seen = mem_we; addr_seen = mem_addr; end
      if (cpu_ready) begin lat = c; rdata = cpu_rdata; fault = fault_w; break; end
    end
    cpu_valid = 1'b0;
    checks++;
    if (lat == 0) begin
      errors++; $display("FAIL cpu_timeout addr=%h no cpu_ready within 12 cycles", addr);
    end else begin
      @(posedge clk); #1;
      if (cpu_ready !== 1'b0) begin
        errors++; $display("FAIL cpu_pulse_width got=%b want=0", cpu_ready);
      end
    end
  endtask

  task automatic host_op(input logic [ADDR_W+1:0] addr, input logic we,
                         input logic [7:0] wdata, output logic [7:0] rdata,
                         output int lat, output logic [3:0] we_seen);
    host_req = 1'b1; host_addr = addr; host_we = we; host_wdata = wdata;
    lat = 0; rdata = 8'h0; we_seen = 4'h0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 1) we_seen = mem_we;
      if (host_ack) begin lat = c; rdata = host_rdata; break; end
    end
    host_req = 1'b0;
    checks++;
    if (lat == 0) begin
      errors++; $display("FAIL host_timeout addr=%h no host_ack within 12 cycles", addr);
    end else begin
      @(posedge clk); #1;
      if (host_ack !== 1'b0) begin
        errors++; $display("FAIL host_pulse_width got=%b want=0", host_ack);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; cpu_valid = 0; cpu_addr = 0; cpu_wdata = 0; cpu_wstrb = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
    repeat (2) @(posedge clk); #1;
    checks++; if ({cpu_ready, host_ack, mem_ce} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses got=%b want=000", {cpu_ready, host_ack, mem_ce}); end
    checks++; if (mem_we !== 4'h0 || mem_addr !== '0 || mem_di !== 32'h0) begin
      errors++; $display("FAIL reset_mem got we=%h addr=%h di=%h want 0", mem_we, mem_addr, mem_di); end
    checks++; if (cpu_rdata !== 32'h0 || host_rdata !== 8'h0) begin
      errors++; $display("FAIL reset_rdata got cpu=%h host=%h want 0", cpu_rdata, host_rdata); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_cpu_rw;
    logic [31:0] rd; int lat; logic [3:0] we; logic [ADDR_W-1:0] ad; logic f;
    cpu_op(32'h200, 32'hDEADBEEF, 4'hF, rd, lat, we, ad, f);
    checks++; if (lat != 3) begin errors++; $display("FAIL cpu_wr_latency got=%0d want=3", lat); end
    checks++; if (we !== 4'hF || ad !== 10'h080) begin
      errors++; $display("FAIL cpu_wr_access got we=%h addr=%h want F/080", we, ad); end
    cpu_op(32'h200, 32'h0, 4'h0, rd, lat, we, ad, f);
    checks++; if (lat != 3) begin errors++; $display("FAIL cpu_rd_latency got=%0d want=3", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL cpu_rd_data got=%h want=DEADBEEF", rd); end
  endtask

  task automatic test_strobe;
    logic [31:0] rd; int lat; logic [3:0] we; logic [ADDR_W-1:0] ad; logic f;
    cpu_op(32'h204, 32'h11223344, 4'hF, rd, lat, we, ad, f);
    checks++; if (cpu_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rdata_hold_on_write got=%h want=DEADBEEF", cpu_rdata); end
    cpu_op(32'h204, 32'h00AA0000, 4'b0100, rd, lat, we, ad, f);
    checks++; if (we !== 4'b0100) begin
      errors++; $display("FAIL strobe_we got=%b want=0100", we); end
    cpu_op(32'h204, 32'h0, 4'h0, rd, lat, we, ad, f);
    checks++; if (rd !== 32'h11AA3344) begin
      errors++; $display("FAIL strobe_data got=%h want=11AA3344", rd); end
  endtask

  task automatic test_host;
    logic [7:0] hb; logic [31:0] rd; int lat; logic [3:0] we; logic [ADDR_W-1:0] ad; logic f;
    host_op(12'h403, 1'b1, 8'h5A, hb, lat, we);
    checks++; if (we !== 4'b1000 || lat != 3) begin
      errors++; $display("FAIL host_wr got we=%b lat=%0d want 1000/3", we, lat); end
    host_op(12'h403, 1'b0, 8'h00, hb, lat, we);
    checks++; if (hb !== 8'h5A) begin errors++; $display("FAIL host_rd_data got=%h want=5A", hb); end
    cpu_op(32'h400, 32'h0, 4'h0, rd, lat, we, ad, f);
    checks++; if (rd[31:24] !== 8'h5A) begin
      errors++; $display("FAIL host_cpu_view got=%h want=5A", rd[31:24]); end
  endtask

  task automatic test_wrap;
    logic [31:0] rd; int lat; logic [3:0] we; logic [ADDR_W-1:0] ad; logic f;
    cpu_op(32'h1200, 32'h0, 4'h0, rd, lat, we, ad, f);
    checks++; if (ad !== 10'h080 || rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL addr_wrap got addr=%h data=%h want 080/DEADBEEF", ad, rd); end
  endtask

  task automatic test_protect;
`ifdef SYSMEM_WRITE_PROTECT_EN
    logic [31:0] rd; int lat; logic [3:0] we; logic [ADDR_W-1:0] ad; logic f;
    cpu_op(32'h010, 32'hCAFEF00D, 4'hF, rd, lat, we, ad, f);
    checks++; if (f !== 1'b1 || we !== 4'h0) begin
      errors++; $display("FAIL prot_fault got fault=%b we=%h want 1/0", f, we); end
    cpu_op(32'h010, 32'h0, 4'h0, rd, lat, we, ad, f);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL prot_mem got=%h want=0", rd); end
    cpu_op(32'h200, 32'hDEADBEEF, 4'hF, rd, lat, we, ad, f);
    checks++; if (f !== 1'b0 || we !== 4'hF) begin
      errors++; $display("FAIL prot_nofault got fault=%b we=%h want 0/F", f, we); end
`endif
  endtask

  task automatic test_back_to_back;
    logic [5:0] seq; int n; int nc; int nh; logic pc; logic ph;
    seq = '0; n = 0; nc = 0; nh = 0; pc = 0; ph = 0;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    cpu_valid = 1; cpu_addr = 32'h200; cpu_wstrb = 0; cpu_wdata = 0;
    host_req = 1; host_we = 0; host_addr = 12'h403;
    for (int c = 0; c < 60 && (nc < 3 || nh < 3); c++) begin
      @(posedge clk); #1;
      if (cpu_ready && host_ack) begin
        checks++; errors++; $display("FAIL b2b_both_pulses at cycle %0d", c); end
      if (cpu_ready) begin
        checks++; if (pc || cpu_rdata !== 32'hDEADBEEF) begin
          errors++; $display("FAIL b2b_cpu got prev=%b data=%h want 0/DEADBEEF", pc, cpu_rdata); end
        if (n < 6) seq[n] = 1'b0;
        n++; nc++;
        if (nc == 3) cpu_valid = 0;
      end
      if (host_ack) begin
        checks++; if (ph || host_rdata !== 8'h5A) begin
          errors++; $display("FAIL b2b_host got prev=%b data=%h want 0/5A", ph, host_rdata); end
        if (n < 6) seq[n] = 1'b1;
        n++; nh++;
        if (nh == 3) host_req = 0;
      end
      pc = cpu_ready; ph = host_ack;
    end
    cpu_valid = 0; host_req = 0;
    checks++; if (nc != 3 || nh != 3) begin
      errors++; $display("FAIL b2b_count got cpu=%0d host=%0d want 3/3", nc, nh); end
    checks++; if (seq !== 6'b101010) begin
      errors++; $display("FAIL b2b_order got=%b want=101010", seq); end
    @(posedge clk); #1;
    checks++; if (cpu_ready !== 1'b0 || host_ack !== 1'b0) begin
      errors++; $display("FAIL b2b_tail got ready=%b ack=%b want 0/0", cpu_ready, host_ack); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int lat;
    lat = 0;
    cpu_valid = 1; cpu_addr = 32'h200; cpu_wstrb = 0; cpu_wdata = 32'h12345678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (mem_addr !== 10'h080 || mem_di !== 32'h12345678) begin
      errors++; $display("FAIL mid_precheck got addr=%h di=%h want 080/12345678", mem_addr, mem_di); end
    rst = 1'b1; #1;
    checks++; if (mem_ce !== 0 || mem_we !== 0 || mem_addr !== '0 || mem_di !== 0 || cpu_ready !== 0) begin
      errors++; $display("FAIL mid_reset got ce=%b we=%h addr=%h di=%h rdy=%b want all 0",
                         mem_ce, mem_we, mem_addr, mem_di, cpu_ready); end
    @(posedge clk); #1;
    checks++; if (cpu_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset_ready got=%b want=0", cpu_ready); end
    rst = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (cpu_ready) begin lat = c; break; end
    end
    checks++; if (lat != 3 || cpu_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL mid_resume got lat=%0d data=%h want 3/DEADBEEF", lat, cpu_rdata); end
    cpu_valid = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_cpu_rw;
    test_strobe;
    test_host;
    test_wrap;
    test_protect;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
